// File: rtl/alk_pkg.sv
// Shared encodings for the ALK multi-step sequencer: op codes, FSM states,
// operand size codes and the operand bit-count helper.
package alk_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_MUL    = 3'd1,
    OP_DIV    = 3'd2,
    OP_DIVDBL = 3'd3,
    OP_REM    = 3'd4,
    OP_SHL    = 3'd5,
    OP_SHR    = 3'd6,
    OP_RSVD   = 3'd7
  } alk_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } alk_state_t;

  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_WORD = 2'b01;
  localparam logic [1:0] DS_LONG = 2'b10;
  localparam logic [1:0] DS_QUAD = 2'b11;

  // Quad collapses to long on a 32-bit datapath.
  function automatic logic [7:0] size_bits(input logic [1:0] dsize, input int dw);
    case (dsize)
      DS_BYTE: size_bits = 8'd8;
      DS_WORD: size_bits = 8'd16;
      DS_LONG: size_bits = 8'd32;
      default: size_bits = (dw == 64) ? 8'd64 : 8'd32;
    endcase
  endfunction

endpackage

// File: rtl/alk_step_cnt.sv
// Loadable step down-counter: subtracts K per enabled cycle, saturates at zero,
// flags the final step cycle (count <= K) and holds while i_go is low.
module alk_step_cnt #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  input  logic          i_go,
  input  logic [CW-1:0] i_k,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  logic [CW-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt <= i_k);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && i_go) begin
      r_cnt <= o_last ? '0 : (r_cnt - i_k);
    end
  end

endmodule

// File: rtl/alk_step_seq.sv
// Multi-step ALU sequencer: ceil(S/K) RUN cycles then one FIN cycle after start.
// stall_l is sampled each edge and freezes/suppresses the following cycle.
module alk_step_seq
  import alk_pkg::*;
#(
  parameter int DW      = 32,
  parameter int NLANE   = DW / 8,
  parameter int DBLSTEP = 0,
  parameter int CW      = $clog2(2 * DW + 2)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start_h,
  input  logic [2:0]       op_h,
  input  logic [1:0]       dsize_h,
  input  logic [CW-1:0]    count_h,
  input  logic             stall_l,
  output logic             busy_h,
  output logic             step_h,
  output logic             dblclk_h,
  output logic             dq_q_shl_l,
  output logic             dq_q_shr_l,
  output logic             alu_sub_op_h,
  output logic             loop_flag_h,
  output logic [NLANE-1:0] lane_we_h,
  output logic             done_h,
  output logic [CW-1:0]    steps_left_h
);

  alk_state_t       r_state;
  alk_op_t          r_op;
  logic             r_dbl;
  logic             r_go;
  logic [NLANE-1:0] r_mask;

  alk_op_t          w_op;
  logic             w_nop;
  logic             w_dbl_op;
  logic [7:0]       w_bits;
  logic [CW-1:0]    w_b;
  logic [CW-1:0]    w_total;
  logic [NLANE-1:0] w_mask;
  logic             w_accept;
  logic [CW-1:0]    w_k;
  logic [CW-1:0]    w_cnt;
  logic             w_last;
  logic             w_step;
  logic             w_done;

  assign w_op     = alk_op_t'(op_h);
  assign w_nop    = (w_op == OP_NOP) || (w_op == OP_RSVD);
  assign w_dbl_op = (DBLSTEP != 0) && (w_op inside {OP_MUL, OP_DIV, OP_DIVDBL});
  assign w_bits   = size_bits(dsize_h, DW);
  assign w_b      = CW'(w_bits);
  assign w_accept = (r_state == ST_IDLE) && start_h && stall_l;
  assign w_k      = r_dbl ? CW'(2) : CW'(1);

  always_comb begin
    w_total = '0;
    case (w_op)
      OP_MUL, OP_DIV: w_total = w_b;
      OP_DIVDBL:      w_total = w_b + w_b;
      OP_REM:         w_total = w_b + CW'(1);
      OP_SHL, OP_SHR: w_total = (count_h < w_b) ? count_h : w_b;
      default:        w_total = '0;
    endcase
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NLANE; i++) begin
      w_mask[i] = !w_nop && (i < int'(w_bits >> 3));
    end
  end

  alk_step_cnt #(.CW(CW)) u_cnt (
    .clk        (clk),
    .i_rst_n    (reset_l),
    .i_load     (w_accept),
    .i_load_val (w_nop ? '0 : w_total),
    .i_dec      (r_state == ST_RUN),
    .i_go       (r_go),
    .i_k        (w_k),
    .o_cnt      (w_cnt),
    .o_last     (w_last)
  );

  // r_go is stall_l from the previous edge, so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_dbl   <= 1'b0;
      r_go    <= 1'b0;
      r_mask  <= '0;
    end else begin
      r_go <= stall_l;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= w_nop ? OP_NOP : w_op;
            r_dbl   <= w_dbl_op;
            r_mask  <= w_mask;
            r_state <= (w_nop || (w_total == '0)) ? ST_FIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_go && w_last) r_state <= ST_FIN;
        end
        ST_FIN: begin
          if (r_go) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_step = (r_state == ST_RUN) && r_go;
  assign w_done = (r_state == ST_FIN) && r_go;

  assign busy_h       = (r_state != ST_IDLE);
  assign step_h       = w_step;
  assign dblclk_h     = w_step && r_dbl && (w_cnt >= CW'(2));
  assign dq_q_shl_l   = !(w_step && (r_op inside {OP_DIV, OP_DIVDBL, OP_REM, OP_SHL}));
  assign dq_q_shr_l   = !(w_step && (r_op inside {OP_MUL, OP_SHR}));
  // The last REM step is the restore and never subtracts.
  assign alu_sub_op_h = w_step && ((r_op == OP_DIV) || (r_op == OP_DIVDBL) ||
                                   ((r_op == OP_REM) && (w_cnt != CW'(1))));
  assign loop_flag_h  = w_step && w_last;
  assign done_h       = w_done;
  assign lane_we_h    = w_done ? r_mask : '0;
  assign steps_left_h = w_cnt;

endmodule

// File: tb/tb_alk_step_seq.sv
// Bench for alk_step_seq: a 32-bit single-step and a 64-bit double-step instance
// share stimulus and are checked every cycle against a step-schedule model.
module tb_alk_step_seq;

  localparam int CW32 = $clog2(2 * 32 + 2);
  localparam int CW64 = $clog2(2 * 64 + 2);

  logic            clk = 1'b0;
  logic            reset_l = 1'b0;
  logic            start_h = 1'b0;
  logic [2:0]      op_h = 3'd0;
  logic [1:0]      dsize_h = 2'd0;
  logic [CW32-1:0] count32 = '0;
  logic [CW64-1:0] count64 = '0;
  logic            stall_l = 1'b1;

  logic busy32, step32, dbl32, shl32, shr32, sub32, loop32, done32;
  logic busy64, step64, dbl64, shl64, shr64, sub64, loop64, done64;
  logic [3:0]      lane32;
  logic [7:0]      lane64;
  logic [CW32-1:0] left32;
  logic [CW64-1:0] left64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alk_step_seq #(.DW(32), .NLANE(4), .DBLSTEP(0), .CW(CW32)) u32 (
    .clk(clk), .reset_l(reset_l), .start_h(start_h), .op_h(op_h), .dsize_h(dsize_h),
    .count_h(count32), .stall_l(stall_l), .busy_h(busy32), .step_h(step32),
    .dblclk_h(dbl32), .dq_q_shl_l(shl32), .dq_q_shr_l(shr32), .alu_sub_op_h(sub32),
    .loop_flag_h(loop32), .lane_we_h(lane32), .done_h(done32), .steps_left_h(left32)
  );

  alk_step_seq #(.DW(64), .NLANE(8), .DBLSTEP(1), .CW(CW64)) u64 (
    .clk(clk), .reset_l(reset_l), .start_h(start_h), .op_h(op_h), .dsize_h(dsize_h),
    .count_h(count64), .stall_l(stall_l), .busy_h(busy64), .step_h(step64),
    .dblclk_h(dbl64), .dq_q_shl_l(shl64), .dq_q_shr_l(shr64), .alu_sub_op_h(sub64),
    .loop_flag_h(loop64), .lane_we_h(lane64), .done_h(done64), .steps_left_h(left64)
  );

  typedef struct {
    int busy, step, dbl, shl_l, shr_l, sub, loop, done, lane, left;
  } rec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: the schedule of a whole operation ----------------
  function automatic int bits_of(input int dw, input int ds);
    case (ds)
      0: return 8;
      1: return 16;
      2: return 32;
      default: return (dw == 64) ? 64 : 32;
    endcase
  endfunction

  function automatic int total_of(input int dw, input int op, input int ds, input int cnt);
    int b;
    b = bits_of(dw, ds);
    case (op)
      1, 2: return b;
      3: return 2 * b;
      4: return b + 1;
      5, 6: return (cnt < b) ? cnt : b;
      default: return 0;
    endcase
  endfunction

  function automatic int k_of(input int inst, input int op);
    return (inst == 1 && op >= 1 && op <= 3) ? 2 : 1;
  endfunction

  function automatic int runs_of(input int inst, input int op, input int ds, input int cnt);
    int s, k;
    s = total_of(inst == 0 ? 32 : 64, op, ds, cnt);
    k = k_of(inst, op);
    return (s + k - 1) / k;
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r = '{busy: 0, step: 0, dbl: 0, shl_l: 1, shr_l: 1, sub: 0, loop: 0, done: 0, lane: 0, left: 0};
    return r;
  endfunction

  function automatic rec_t seq_rec(input int inst, input int op, input int ds, input int cnt, input int idx);
    rec_t r;
    int dw, s, k, left, n;
    dw = (inst == 0) ? 32 : 64;
    s = total_of(dw, op, ds, cnt);
    k = k_of(inst, op);
    r = idle_rec();
    r.busy = 1;
    if (idx < runs_of(inst, op, ds, cnt)) begin
      left = s - idx * k;
      n = (left < k) ? left : k;
      r.step = 1;
      r.dbl = int'(n == 2);
      r.loop = int'(left <= k);
      r.sub = int'(op == 2 || op == 3 || (op == 4 && left > 1));
      r.shl_l = int'(!(op >= 2 && op <= 5));
      r.shr_l = int'(!(op == 1 || op == 6));
      r.left = left;
    end else begin
      r.done = 1;
      r.lane = (op == 0 || op == 7) ? 0 : ((1 << (bits_of(dw, ds) / 8)) - 1);
    end
    return r;
  endfunction

  int m_op[2], m_ds[2], m_cnt[2], m_idx[2];
  bit m_busy[2], m_go[2];

  always @(posedge clk or negedge reset_l) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_l) begin
        m_busy[i] = 1'b0;
        m_go[i] = 1'b0;
        m_idx[i] = 0;
      end else begin
        if (m_busy[i]) begin
          if (m_go[i]) begin
            m_idx[i]++;
            if (m_idx[i] > runs_of(i, m_op[i], m_ds[i], m_cnt[i])) m_busy[i] = 1'b0;
          end
        end else if (start_h && stall_l) begin
          m_op[i] = int'(op_h);
          m_ds[i] = int'(dsize_h);
          m_cnt[i] = int'(count64);
          m_idx[i] = 0;
          m_busy[i] = 1'b1;
        end
        m_go[i] = stall_l;
      end
    end
  end

  function automatic rec_t expect_rec(input int i);
    rec_t r, h;
    r = idle_rec();
    if (m_busy[i]) begin
      h = seq_rec(i, m_op[i], m_ds[i], m_cnt[i], m_idx[i]);
      if (m_go[i]) r = h;
      else begin
        r.busy = 1;
        r.left = h.left;
      end
    end
    return r;
  endfunction

  task automatic cmp_rec(input string tag, input rec_t e, input rec_t a);
    chk({tag, ".busy"}, a.busy, e.busy);
    chk({tag, ".step"}, a.step, e.step);
    chk({tag, ".dblclk"}, a.dbl, e.dbl);
    chk({tag, ".shl_l"}, a.shl_l, e.shl_l);
    chk({tag, ".shr_l"}, a.shr_l, e.shr_l);
    chk({tag, ".sub"}, a.sub, e.sub);
    chk({tag, ".loop"}, a.loop, e.loop);
    chk({tag, ".done"}, a.done, e.done);
    chk({tag, ".lane"}, a.lane, e.lane);
    chk({tag, ".left"}, a.left, e.left);
  endtask

  always @(negedge clk) begin
    rec_t a;
    a = '{busy: int'(busy32), step: int'(step32), dbl: int'(dbl32), shl_l: int'(shl32),
          shr_l: int'(shr32), sub: int'(sub32), loop: int'(loop32), done: int'(done32),
          lane: int'(lane32), left: int'(left32)};
    cmp_rec("cyc32", expect_rec(0), a);
    a = '{busy: int'(busy64), step: int'(step64), dbl: int'(dbl64), shl_l: int'(shl64),
          shr_l: int'(shr64), sub: int'(sub64), loop: int'(loop64), done: int'(done64),
          lane: int'(lane64), left: int'(left64)};
    cmp_rec("cyc64", expect_rec(1), a);
  end

  // ---------------- directed stimulus ----------------
  // Cycle c is the cycle after edge c-1; the start is taken at edge 0.
  task automatic run_op(input int op, input int ds, input int cnt,
                        input int stall_at, input int stall_len, input int restart_at,
                        output int d32, output int d64, output int s32, output int s64,
                        output int db64, output int sb32, output int l32, output int l64);
    d32 = -1; d64 = -1; s32 = 0; s64 = 0; db64 = 0; sb32 = 0; l32 = -1; l64 = -1;
    @(posedge clk); #1;
    start_h = 1'b1;
    op_h = op[2:0];
    dsize_h = ds[1:0];
    count32 = cnt[CW32-1:0];
    count64 = cnt[CW64-1:0];
    @(posedge clk); #1;
    start_h = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      stall_l = !(c >= stall_at && c < stall_at + stall_len);
      start_h = (c == restart_at);
      @(negedge clk);
      if (step32) s32++;
      if (step64) s64++;
      if (dbl64) db64++;
      if (sub32) sb32++;
      if (done32 && d32 < 0) begin d32 = c; l32 = int'(lane32); end
      if (done64 && d64 < 0) begin d64 = c; l64 = int'(lane64); end
      @(posedge clk); #1;
      if (d32 >= 0 && d64 >= 0) break;
    end
    start_h = 1'b0;
    stall_l = 1'b1;
  endtask

  initial begin
    int d32, d64, s32, s64, db64, sb32, l32, l64;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy32", int'(busy32), 0);
    chk("rst.shl32", int'(shl32), 1);
    chk("rst.shr32", int'(shr32), 1);
    chk("rst.left32", int'(left32), 0);
    chk("rst.lane64", int'(lane64), 0);
    chk("rst.done64", int'(done64), 0);
    reset_l = 1'b1;

    // MUL long
    run_op(1, 2, 0, 0, 0, 0, d32, d64, s32, s64, db64, sb32, l32, l64);
    chk("mul.done32", d32, 33);
    chk("mul.steps32", s32, 32);
    chk("mul.lane32", l32, 15);
    chk("mul.done64", d64, 17);
    chk("mul.dbl64", db64, 16);
    chk("mul.lane64", l64, 15);

    // REM byte: 8 subtract steps plus a restore
    run_op(4, 0, 0, 0, 0, 0, d32, d64, s32, s64, db64, sb32, l32, l64);
    chk("rem.done32", d32, 10);
    chk("rem.steps32", s32, 9);
    chk("rem.sub32", sb32, 8);
    chk("rem.lane32", l32, 1);
    chk("rem.done64", d64, 10);

    // DIVDBL quad: 128 steps two at a time on the 64-bit instance
    run_op(3, 3, 0, 0, 0, 0, d32, d64, s32, s64, db64, sb32, l32, l64);
    chk("divdbl.done64", d64, 65);
    chk("divdbl.dbl64", db64, 64);
    chk("divdbl.lane64", l64, 255);
    chk("divdbl.done32", d32, 65);
    chk("divdbl.lane32", l32, 15);

    // SHL with zero count
    run_op(5, 1, 0, 0, 0, 0, d32, d64, s32, s64, db64, sb32, l32, l64);
    chk("shl0.done32", d32, 1);
    chk("shl0.steps32", s32, 0);
    chk("shl0.done64", d64, 1);

    // SHR word with count clamped
    run_op(6, 1, 40, 0, 0, 0, d32, d64, s32, s64, db64, sb32, l32, l64);
    chk("shr.steps32", s32, 16);
    chk("shr.done32", d32, 17);
    chk("shr.steps64", s64, 16);

    // DIV long, 3-cycle stall mid-run and a stray start
    run_op(2, 2, 0, 5, 3, 3, d32, d64, s32, s64, db64, sb32, l32, l64);
    chk("stall.done32", d32, 36);
    chk("stall.steps32", s32, 32);
    chk("stall.done64", d64, 20);
    chk("stall.steps64", s64, 16);

    // reserved op behaves as NOP
    run_op(7, 0, 0, 0, 0, 0, d32, d64, s32, s64, db64, sb32, l32, l64);
    chk("nop.done32", d32, 1);
    chk("nop.lane32", l32, 0);

    // asynchronous reset mid-run
    @(posedge clk); #1;
    start_h = 1'b1; op_h = 3'd1; dsize_h = 2'd2;
    @(posedge clk); #1;
    start_h = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("prerst.busy32", int'(busy32), 1);
    reset_l = 1'b0;
    #1;
    chk("arst.busy32", int'(busy32), 0);
    chk("arst.step32", int'(step32), 0);
    chk("arst.shr32", int'(shr32), 1);
    chk("arst.left32", int'(left32), 0);
    chk("arst.busy64", int'(busy64), 0);
    chk("arst.left64", int'(left64), 0);
    @(posedge clk); #1;
    reset_l = 1'b1;

    run_op(1, 0, 0, 0, 0, 0, d32, d64, s32, s64, db64, sb32, l32, l64);
    chk("post.done32", d32, 9);
    chk("post.done64", d64, 5);
    chk("post.lane64", l64, 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alk_step_seq.md
# alk_step_seq

Parametrised multi-step ALU sequencer for the DPM datapath. It sits beside the ALK micro-op decoder and takes over once a multi-cycle ALPCTL class is decoded: MUL, DIV, DIVDBL, REM, SHL or SHR. It owns the step counter and the loop flag, and drives the per-step DQ/ALU shift/subtract controls and the final scratchpad byte-lane write enables. Unlike the fixed 32-bit decoder, it is generic in datapath width and supports two steps per cycle.

## Interface
Parameters:
- DW, 32: datapath width in bits; legal values are 32 and 64.
- NLANE, DW/8: number of scratchpad byte lanes.
- DBLSTEP, 0: when 1, MUL/DIV/DIVDBL perform two steps per cycle.
- CW, $clog2(2*DW+2): width of the step counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_l  in  1  asynchronous, active-low reset.
- start_h  in  1  request a new operation; accepted only in IDLE.
- op_h  in  3  operation code: 0 NOP, 1 MUL, 2 DIV, 3 DIVDBL, 4 REM, 5 SHL, 6 SHR, 7 reserved (treated as NOP).
- dsize_h  in  2  operand size: 00 byte, 01 word, 10 long, 11 quad. Quad is treated as long when DW=32.
- count_h  in  CW  shift count; used by SHL/SHR only.
- stall_l  in  1  low freezes all state and all step outputs.
- busy_h  out  1  sequencer is in RUN or FIN.
- step_h  out  1  a datapath step is active this cycle.
- dblclk_h  out  1  the current step cycle performs two steps.
- dq_q_shl_l  out  1  Q register shifts left (DIV, DIVDBL, REM, SHL).
- dq_q_shr_l  out  1  Q register shifts right (MUL, SHR).
- alu_sub_op_h  out  1  ALU subtracts (DIV, DIVDBL, REM; REM restore step excluded).
- loop_flag_h  out  1  last RUN cycle.
- lane_we_h  out  NLANE  byte-lane write enables; asserted in FIN only.
- done_h  out  1  one-cycle completion pulse.
- steps_left_h  out  CW  number of steps remaining.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: on start_h, latch op_h, dsize_h and the step total S, then go to RUN.
  - If S=0 or the op is NOP, go directly to FIN.
- Bit count B by dsize_h: 8, 16, 32 or 64.
- Step total S:
  - MUL and DIV: S=B.
  - DIVDBL: S=2B.
  - REM: S=B+1, where the final step is a restore with alu_sub_op_h=0.
  - SHL and SHR: S=min(count_h, B).
- RUN: each unstalled cycle decrements steps_left_h by K.
  - K=2 when DBLSTEP=1 and the op is MUL, DIV or DIVDBL; otherwise K=1.
  - An odd remainder finishes with a single step; dblclk_h is 0 in that cycle.
  - loop_flag_h=1 when steps_left_h≤K. On that cycle, move to FIN.
- FIN: assert done_h for one cycle. Set lane_we_h bits [B/8-1:0]; NLANE-1 down to B/8 are 0. NOP gives lane_we_h=0. Return to IDLE.
- Step outputs are valid only in RUN with stall_l=1; otherwise they sit at their inactive level.
- stall_l=0 holds state, the counter and latched fields. It suppresses step_h, done_h and lane_we_h; the pending FIN pulse is delayed, not lost.
- start_h in RUN or FIN is ignored; there is no queueing.
- start_h in IDLE with stall_l=0 is not accepted.
- reset_l low at any time forces IDLE.

## Timing
- Reset values: busy_h=0, step_h=0, dblclk_h=0, dq_q_shl_l=1, dq_q_shr_l=1, alu_sub_op_h=0, loop_flag_h=0, lane_we_h=0, done_h=0, steps_left_h=0.
- Start accepted at edge 0. The first step occurs in cycle 1. RUN lasts ceil(S/K) cycles, then FIN for one cycle.
- Total latency from start to done_h is ceil(S/K)+1 cycles.
- busy_h drops in the cycle after FIN. The earliest next start is that cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package alk_pkg holds:
  - the op_h encodings and the alk_state_t enum;
  - the dsize codes;
  - the function size_bits(dsize, DW).
- One sub-module: alk_step_cnt. It is the loadable down-counter with decrement K, the ≤K terminal detect and stall hold.
- The top level holds the FSM and the output decode.

## Test plan
- DW=32, DBLSTEP=0, MUL long: 32 RUN cycles with dq_q_shr_l=0; loop_flag_h in cycle 32; done_h and lane_we_h=4'hF in cycle 33.
- DW=32, REM byte: 9 RUN cycles; alu_sub_op_h=1 in cycles 1–8 and 0 in cycle 9; lane_we_h=4'h1.
- DW=64, DBLSTEP=1, DIVDBL quad: 128 steps in 64 RUN cycles with dblclk_h=1 throughout; lane_we_h=8'hFF in cycle 65.
- SHL with count_h=0: no step_h; done_h in cycle 1. SHR word with count_h=40: clamps to 16 steps.
- stall_l=0 for 3 cycles mid-RUN: steps_left_h frozen and step_h=0; done_h arrives 3 cycles late. A start_h issued during RUN is ignored.
- reset_l pulsed low mid-RUN (asynchronously, between edges): all outputs take their reset values immediately; a new start after release runs a full sequence.
